// File: rtl/set_event_pkg.sv
// Shared types and default widths for the set_event stimulus driver.
package set_event_pkg;

  localparam int unsigned DefSetSize  = 16;
  localparam int unsigned DefSetWidth = 4;
  localparam int unsigned DefCntWidth = 16;

  typedef enum logic [1:0] {
    SET_HIGH,
    SET_LOW,
    PULSE_HIGH,
    PULSE_LOW
  } set_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE,
    DONE
  } set_state_t;

endpackage

// File: rtl/set_event_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module set_event_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/set_event_tb.sv
// Drives one bit of a signal bus after a programmable delay: level set/clear or
// a high/low pulse. Outputs are registered; one command at a time.
module set_event_tb
  import set_event_pkg::*;
#(
  parameter int unsigned         SET_SIZE   = DefSetSize,
  parameter int unsigned         SET_WIDTH  = DefSetWidth,
  parameter int unsigned         CNT_WIDTH  = DefCntWidth,
  parameter logic [SET_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_en,
  input  logic [SET_WIDTH-1:0] i_sel,
  input  logic [1:0]           i_mode,
  input  logic [CNT_WIDTH-1:0] i_delay,
  input  logic [CNT_WIDTH-1:0] i_pulse_width,
  output logic [SET_SIZE-1:0]  o_set_signals,
  output logic                 o_busy,
  output logic                 o_set_done,
  output logic                 o_sel_err
);

  localparam logic [SET_WIDTH:0] SizeL = (SET_WIDTH + 1)'(SET_SIZE);

  set_state_t           state_q, state_d;
  set_mode_t            mode_q;
  logic [SET_WIDTH-1:0] sel_q;
  logic [CNT_WIDTH-1:0] width_q;
  logic [SET_SIZE-1:0]  sig_q, sig_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 capture;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_val, width_m1;
  logic                 drive_en, drive_lvl;
  logic                 sel_ok;

  assign sel_ok   = ({1'b0, sel_q} < SizeL);
  // A zero pulse width still yields a one-cycle pulse.
  assign width_m1 = (width_q == '0) ? '0 : width_q - CNT_WIDTH'(1);

  set_event_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = i_delay;
    drive_en  = 1'b0;
    drive_lvl = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_set_en) begin
          capture  = 1'b1;
          cnt_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = DELAY;
        end
      end
      DELAY: begin
        if (cnt_zero) begin
          drive_en  = 1'b1;
          drive_lvl = (mode_q == SET_HIGH) || (mode_q == PULSE_HIGH);
          if ((mode_q == PULSE_HIGH) || (mode_q == PULSE_LOW)) begin
            cnt_load = 1'b1;
            cnt_val  = width_m1;
            state_d  = PULSE;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = !sel_ok;
            state_d = DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          drive_en  = 1'b1;
          drive_lvl = (mode_q == PULSE_LOW);
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = !sel_ok;
          state_d   = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sig_d = sig_q;
    for (int unsigned i = 0; i < SET_SIZE; i++) begin
      if (drive_en && sel_ok && (sel_q == SET_WIDTH'(i))) begin
        sig_d[i] = drive_lvl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SET_HIGH;
      sel_q   <= '0;
      width_q <= '0;
      sig_q   <= INIT_VALUE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (capture) begin
        mode_q  <= set_mode_t'(i_mode);
        sel_q   <= i_sel;
        width_q <= i_pulse_width;
      end
    end
  end

  assign o_set_signals = sig_q;
  assign o_busy        = busy_q;
  assign o_set_done    = done_q;
  assign o_sel_err     = err_q;

endmodule

// File: tb/tb_set_event_tb.sv
// Bench for set_event_tb: a 16-bit and a 12-bit instance share stimulus and are
// checked every cycle against a timeline model of each command.
module tb_set_event_tb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_set_en = 1'b0;
  logic [3:0]  i_sel = '0;
  logic [1:0]  i_mode = '0;
  logic [15:0] i_delay = '0;
  logic [15:0] i_pulse_width = '0;

  logic [15:0] sig0;
  logic        busy0, done0, err0;
  logic [11:0] sig1;
  logic        busy1, done1, err1;

  always #5 clk = ~clk;

  set_event_tb #(
    .SET_SIZE  (16),
    .SET_WIDTH (4),
    .CNT_WIDTH (16),
    .INIT_VALUE(16'h00F0)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (i_set_en),
    .i_sel        (i_sel),
    .i_mode       (i_mode),
    .i_delay      (i_delay),
    .i_pulse_width(i_pulse_width),
    .o_set_signals(sig0),
    .o_busy       (busy0),
    .o_set_done   (done0),
    .o_sel_err    (err0)
  );

  set_event_tb #(
    .SET_SIZE  (12),
    .SET_WIDTH (4),
    .CNT_WIDTH (16),
    .INIT_VALUE(12'h0F0)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (i_set_en),
    .i_sel        (i_sel),
    .i_mode       (i_mode),
    .i_delay      (i_delay),
    .i_pulse_width(i_pulse_width),
    .o_set_signals(sig1),
    .o_busy       (busy1),
    .o_set_done   (done1),
    .o_sel_err    (err1)
  );

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Model: each accepted command is a pair of absolute edge numbers.
  bit          m_pending = 0;
  int          m_sel, m_mode, m_chg, m_end;
  int          m_idle_from = 0;
  logic [15:0] m_bus0 = 16'h00F0;
  logic [11:0] m_bus1 = 12'h0F0;
  bit          m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_apply(input logic lvl);
    if (m_sel < 16) m_bus0[m_sel] = lvl;
    if (m_sel < 12) m_bus1[m_sel] = lvl;
  endtask

  task automatic model_reset();
    m_pending   = 0;
    m_done      = 0;
    m_idle_from = 0;
    m_bus0      = 16'h00F0;
    m_bus1      = 12'h0F0;
  endtask

  task automatic model_step();
    int w;
    m_done = 0;
    if (!rst_n) return;
    if (m_pending) begin
      if (edge_n == m_chg) model_apply(m_mode == 0 || m_mode == 2);
      if (edge_n == m_end) begin
        if (m_mode >= 2) model_apply(m_mode == 3);
        m_done      = 1;
        m_pending   = 0;
        m_idle_from = edge_n + 2;
      end
    end else if (edge_n >= m_idle_from && i_set_en) begin
      m_sel     = int'(i_sel);
      m_mode    = int'(i_mode);
      w         = (i_pulse_width == 0) ? 1 : int'(i_pulse_width);
      m_chg     = edge_n + int'(i_delay) + 1;
      m_end     = (m_mode < 2) ? m_chg : m_chg + w;
      m_pending = 1;
    end
  endtask

  task automatic compare_all();
    chk("bus0", 32'(sig0), 32'(m_bus0));
    chk("busy0", 32'(busy0), 32'(m_pending));
    chk("done0", 32'(done0), 32'(m_done));
    chk("err0", 32'(err0), 32'(m_done && m_sel >= 16));
    chk("bus1", 32'(sig1), 32'(m_bus1));
    chk("busy1", 32'(busy1), 32'(m_pending));
    chk("done1", 32'(done1), 32'(m_done));
    chk("err1", 32'(err1), 32'(m_done && m_sel >= 12));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic scramble();
    i_sel         = 4'($urandom);
    i_mode        = 2'($urandom);
    i_delay       = 16'($urandom);
    i_pulse_width = 16'($urandom);
  endtask

  task automatic issue(input logic [3:0] sel, input logic [1:0] mode,
                       input logic [15:0] d, input logic [15:0] w);
    i_set_en      = 1'b1;
    i_sel         = sel;
    i_mode        = mode;
    i_delay       = d;
    i_pulse_width = w;
    tick();
    i_set_en = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done0 && n < 2000);
    if (!done0) chk("done_timeout", 32'(n), 32'(0));
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  mode;
    logic [15:0] delay;
    logic [15:0] width;
    int          lat;
    logic        fin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, cnt;

    vecs[0] = '{4'd3,  2'd0, 16'd5, 16'd0, 6, 1'b1};  // level set
    vecs[1] = '{4'd7,  2'd2, 16'd0, 16'd4, 5, 1'b0};  // high pulse on a bit at 1
    vecs[2] = '{4'd7,  2'd2, 16'd0, 16'd0, 2, 1'b0};  // zero width -> 1 cycle
    vecs[3] = '{4'd0,  2'd3, 16'd2, 16'd3, 6, 1'b1};  // low pulse on a bit at 0
    vecs[4] = '{4'd15, 2'd0, 16'd1, 16'd0, 2, 1'b1};  // invalid on 12-bit dut
    vecs[5] = '{4'd4,  2'd1, 16'd0, 16'd0, 1, 1'b0};  // level clear
    vecs[6] = '{4'd3,  2'd0, 16'd3, 16'd0, 4, 1'b1};  // already at target
    vecs[7] = '{4'd14, 2'd3, 16'd1, 16'd1, 3, 1'b1};  // invalid low pulse

    #12;
    chk("reset_bus0", 32'(sig0), 32'h00F0);
    chk("reset_bus1", 32'(sig1), 32'h00F0);
    chk("reset_busy", 32'({busy0, busy1}), 32'(0));
    chk("reset_done", 32'({done0, done1, err0, err1}), 32'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    foreach (vecs[k]) begin
      issue(vecs[k].sel, vecs[k].mode, vecs[k].delay, vecs[k].width);
      wait_done(n);
      chk("latency", 32'(n), 32'(vecs[k].lat));
      chk("final_bit", 32'(sig0[vecs[k].sel]), 32'(vecs[k].fin));
      tick();
    end

    // Second strobe during DELAY must be dropped.
    issue(4'd5, 2'd0, 16'd6, 16'd0);
    repeat (2) tick();
    i_set_en = 1'b1; i_sel = 4'd6; i_mode = 2'd1; i_delay = 16'd0;
    tick();
    i_set_en = 1'b0;
    wait_done(n);
    chk("ignored_latency", 32'(n), 32'(4));
    cnt = 0;
    repeat (10) begin
      tick();
      if (done0) cnt++;
    end
    chk("single_done", 32'(cnt), 32'(0));
    chk("ignored_bit6", 32'(sig0[6]), 32'(1));

    // Strobe held high: the edge ending DONE does not accept.
    i_set_en = 1'b1; i_sel = 4'd1; i_mode = 2'd0; i_delay = 16'd0; i_pulse_width = 16'd0;
    tick();
    tick();
    chk("held_done", 32'(done0), 32'(1));
    tick();
    chk("held_idle_busy", 32'(busy0), 32'(0));
    tick();
    chk("held_accept_busy", 32'(busy0), 32'(1));
    i_set_en = 1'b0;
    wait_done(n);
    tick();

    // Reset in the middle of a pulse.
    issue(4'd9, 2'd2, 16'd1, 16'd8);
    repeat (4) tick();
    chk("pulse_active", 32'(sig0[9]), 32'(1));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_bus0", 32'(sig0), 32'h00F0);
    chk("midrst_bus1", 32'(sig1), 32'h00F0);
    chk("midrst_busy", 32'({busy0, busy1, done0, done1}), 32'(0));
    tick();
    #3 rst_n = 1'b1;
    repeat (12) tick();
    issue(4'd9, 2'd0, 16'd0, 16'd0);
    wait_done(n);
    chk("post_rst_latency", 32'(n), 32'(1));
    tick();

    // Randomized traffic, checked cycle by cycle.
    repeat (500) begin
      i_set_en      = ($urandom_range(0, 2) == 0);
      i_sel         = 4'($urandom);
      i_mode        = 2'($urandom);
      i_delay       = 16'($urandom_range(0, 7));
      i_pulse_width = 16'($urandom_range(0, 5));
      tick();
    end
    i_set_en = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
